// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the iterative shift-add multiplier.
// The optional signed mode is enabled by defining SEQ_MUL_SIGNED_EN.
package seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Bits needed to hold an iteration count of 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_step.sv
// One partial-product step: conditionally add the multiplicand into the
// upper half of the accumulator (keeping the carry), then shift right by 1.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH:0]  i_acc,
  input  logic [WIDTH-1:0]  i_mcand,
  output logic [2*WIDTH:0]  o_acc
);

  logic [WIDTH:0] w_sum;

  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_mcand};

  // Select add-then-shift or plain shift on the accumulator LSB.
  always_comb begin
    o_acc = {1'b0, i_acc[2*WIDTH:1]};
    if (i_acc[0]) begin
      o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one
// partial-product step per clock, start/finish handshake shared with the
// sequential divider. Define SEQ_MUL_SIGNED_EN to add the i_is_signed port
// and two's-complement operation (sign-magnitude with final negation).
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_multiplicand,
  input  logic [WIDTH-1:0]   i_multiplier,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               i_is_signed,
`endif
  output logic               o_busy,
  output logic               o_finish,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int LCNT_W = cnt_width(WIDTH);
  localparam logic [LCNT_W-1:0] LAST_ITER = LCNT_W'(WIDTH - 1);

  state_t              r_state;
  logic [LCNT_W-1:0]   r_cnt;
  logic [2*WIDTH:0]    r_acc;
  logic [WIDTH-1:0]    r_mcand;
  logic                r_busy;
  logic                r_finish;
  logic [2*WIDTH-1:0]  r_product;

  logic [2*WIDTH:0]    w_acc_next;
  logic [WIDTH-1:0]    w_a_lat;
  logic [WIDTH-1:0]    w_b_lat;
  logic [2*WIDTH-1:0]  w_result;
  logic                w_accept;

  // A start is only honoured outside RUN; requests during iteration are dropped.
  assign w_accept = i_start && (r_state != RUN);

`ifdef SEQ_MUL_SIGNED_EN
  logic w_neg_a;
  logic w_neg_b;
  logic r_sign;

  assign w_neg_a = i_is_signed & i_multiplicand[WIDTH-1];
  assign w_neg_b = i_is_signed & i_multiplier[WIDTH-1];
  // The most-negative value negates to itself, which read as unsigned is
  // exactly its magnitude 2^(WIDTH-1), so no special case is needed.
  assign w_a_lat  = w_neg_a ? -i_multiplicand : i_multiplicand;
  assign w_b_lat  = w_neg_b ? -i_multiplier   : i_multiplier;
  assign w_result = r_sign ? -w_acc_next[2*WIDTH-1:0] : w_acc_next[2*WIDTH-1:0];
`else
  assign w_a_lat  = i_multiplicand;
  assign w_b_lat  = i_multiplier;
  assign w_result = w_acc_next[2*WIDTH-1:0];
`endif

  seq_mul_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_acc  (r_acc),
    .i_mcand(r_mcand),
    .o_acc  (w_acc_next)
  );

  // Control FSM, iteration counter, operand/sign latches and result register.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; blocking '=' would let later lines see new values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_busy    <= 1'b0;
      r_finish  <= 1'b0;
      r_product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      r_sign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state  <= RUN;
            r_mcand  <= w_a_lat;
            r_acc    <= {1'b0, {WIDTH{1'b0}}, w_b_lat};
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_finish <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
            r_sign   <= w_neg_a ^ w_neg_b;
`endif
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state   <= DONE;
            r_product <= w_result;
            r_finish  <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_finish  = r_finish;
  assign o_product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier (WIDTH = 32).
// Signed scenarios are compiled in only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_multiplier;

  localparam int W = 32;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   mcand;
  logic [W-1:0]   mplier;
  logic           is_signed;
  logic           busy;
  logic           finish;
  logic [2*W-1:0] product;

  int n_cmp;
  int n_bad;

  seq_multiplier #(.WIDTH(W)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_multiplicand(mcand),
    .i_multiplier  (mplier),
`ifdef SEQ_MUL_SIGNED_EN
    .i_is_signed   (is_signed),
`endif
    .o_busy        (busy),
    .o_finish      (finish),
    .o_product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands before a rising edge, hold start through it, drop it after.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    @(negedge clk);
    start     = 1'b1;
    mcand     = a;
    mplier    = b;
    is_signed = s;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges (start edge included in init) until finish, bounded.
  task automatic wait_done(input int init, output int edges, output bit seen);
    edges = init;
    seen  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (finish) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0; is_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, finish, product} !== {1'b0, 1'b0, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_hold: busy=%0b finish=%0b product=%h, want 0/0/0", busy, finish, product);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, finish, product} !== {1'b0, 1'b0, 64'd0}) begin
      n_bad++;
      $display("FAIL reset_release: busy=%0b finish=%0b product=%h, want 0/0/0", busy, finish, product);
    end
  endtask

  task automatic test_basic();
    int e; bit seen;
    start_op(32'd3, 32'd5, 1'b0);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_busy: busy=%0b, want 1", busy);
    end
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || e != 33) begin
      n_bad++;
      $display("FAIL basic_latency: edges=%0d seen=%0b, want 33/1", e, seen);
    end
    n_cmp++;
    if (product !== 64'h0000_0000_0000_000F) begin
      n_bad++;
      $display("FAIL basic_product: got %h, want 000000000000000f", product);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b0 || finish !== 1'b1 || product !== 64'hF) begin
      n_bad++;
      $display("FAIL basic_hold: busy=%0b finish=%0b product=%h, want 0/1/f", busy, finish, product);
    end
  endtask

  task automatic test_back_to_back();
    int e; bit seen;
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || product !== 64'hFFFF_FFFE_0000_0001) begin
      n_bad++;
      $display("FAIL max_product: got %h seen=%0b, want fffffffe00000001", product, seen);
    end
    // Start issued in the very cycle finish is first high.
    start_op(32'd6, 32'd7, 1'b0);
    n_cmp++;
    if (finish !== 1'b0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: finish=%0b busy=%0b, want 0/1", finish, busy);
    end
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || e != 33 || product !== 64'd42) begin
      n_bad++;
      $display("FAIL b2b_result: edges=%0d product=%h, want 33/2a", e, product);
    end
  endtask

  task automatic test_ignore_start();
    int e; bit seen;
    start_op(32'h1234, 32'h10, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    start = 1'b1; mcand = 32'hFFFF_FFFF; mplier = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, e, seen);
    n_cmp++;
    if (!seen || e != 33 || product !== 64'h12340) begin
      n_bad++;
      $display("FAIL ignore_start: edges=%0d product=%h, want 33/12340", e, product);
    end
  endtask

  task automatic test_reset_abort();
    int e; bit seen; bit any_fin;
    start_op(32'd7, 32'd9, 1'b0);
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, finish, product} !== {1'b0, 1'b0, 64'd0}) begin
      n_bad++;
      $display("FAIL abort_async: busy=%0b finish=%0b product=%h, want 0/0/0", busy, finish, product);
    end
    @(negedge clk);
    rst = 1'b0;
    any_fin = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (finish || busy) any_fin = 1'b1;
    end
    n_cmp++;
    if (any_fin !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_finish: activity=%0b, want 0", any_fin);
    end
    start_op(32'd7, 32'd9, 1'b0);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || e != 33 || product !== 64'd63) begin
      n_bad++;
      $display("FAIL abort_restart: edges=%0d product=%h, want 33/3f", e, product);
    end
  endtask

  task automatic test_zero();
    int e; bit seen;
    start_op(32'd0, 32'hDEAD_BEEF, 1'b0);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || e != 33 || product !== 64'd0) begin
      n_bad++;
      $display("FAIL zero_operand: edges=%0d product=%h, want 33/0", e, product);
    end
    start_op(32'hDEAD_BEEF, 32'd1, 1'b0);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || product !== 64'h0000_0000_DEAD_BEEF) begin
      n_bad++;
      $display("FAIL identity: product=%h, want 00000000deadbeef", product);
    end
  endtask

`ifdef SEQ_MUL_SIGNED_EN
  task automatic test_signed();
    int e; bit seen;
    start_op(32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || e != 33 || product !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_bad++;
      $display("FAIL signed_neg: edges=%0d product=%h, want 33/ffffffffffffffeb", e, product);
    end
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || e != 33 || product !== 64'h4000_0000_0000_0000) begin
      n_bad++;
      $display("FAIL signed_minmin: edges=%0d product=%h, want 33/4000000000000000", e, product);
    end
    start_op(32'hFFFF_FFFD, 32'd7, 1'b0);
    wait_done(1, e, seen);
    n_cmp++;
    if (!seen || product !== 64'h0000_0006_FFFF_FFEB) begin
      n_bad++;
      $display("FAIL signed_off: product=%h, want 00000006ffffffeb", product);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_start();
    test_reset_abort();
    test_zero();
`ifdef SEQ_MUL_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-add multiplier producing a full-width product from two WIDTH-bit operands, one partial-product step per clock. It is the multiply-side counterpart of the sequential divider in the ALU's multi-cycle execution unit and shares the same start/finish handshake, so the pipeline stall logic drives both identically.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only when not busy
- multiplicand  input  WIDTH  operand A; latched on accepted start
- multiplier  input  WIDTH  operand B; latched on accepted start
- is_signed  input  1  two's-complement mode; present only with SEQ_MUL_SIGNED_EN
- busy  output  1  high while iterating
- finish  output  1  result valid; held until the next accepted start
- product  output  2*WIDTH  result; held stable while finish is high

## Operation
- Reset is asynchronous. Reset values: busy=0, finish=0, product=0, state IDLE, counter=0.
- Three states:
  - IDLE: the post-reset state.
  - RUN: iterating.
  - DONE: result presented.
- IDLE/DONE, start=1 → RUN:
  - Latch both operands.
  - acc[2*WIDTH:0] = {0, multiplier}.
  - cnt=0, finish=0, busy=1.
- RUN, each cycle:
  - If acc[0]=1, add the latched multiplicand into acc[2*WIDTH:WIDTH] as a (WIDTH+1)-bit sum keeping the carry.
  - Shift acc right by 1.
  - cnt++.
- RUN, after the WIDTH-th iteration → DONE:
  - product = acc[2*WIDTH-1:0].
  - finish=1, busy=0.
- DONE holds the product and finish until an accepted start. There is no self-clear.
- start while in RUN is ignored. Operand changes during RUN have no effect.
- Zero operands take no early exit; latency is always WIDTH iterations.
- Product is exact modulo 2^(2*WIDTH). It never overflows.

## Timing
- start sampled high at edge N → busy=1 after edge N.
- Iterations occur at edges N+1 … N+WIDTH.
- finish=1 and product valid after edge N+WIDTH. Latency is WIDTH+1 edges from the start edge.
- Back-to-back: start=1 in a DONE cycle is accepted at that edge. finish falls after that edge; the new result appears WIDTH edges later. Peak throughput is one result per WIDTH+1 cycles.
- rst asserted mid-RUN:
  - Aborts immediately to reset values.
  - No finish pulse for the aborted operation.
- rst and start high together: reset wins.

## Configuration
- SEQ_MUL_SIGNED_EN defined:
  - The is_signed port exists.
  - With is_signed=1 at the start edge:
    - Both operands are replaced by their magnitudes when latched.
    - The sign (A[MSB] XOR B[MSB]) is stored.
    - The final product is two's-complement negated on the DONE transition if the sign is 1.
  - Latency is unchanged.
  - The most-negative operand is handled by treating its magnitude as the unsigned value 2^(WIDTH-1).
  - With is_signed=0, behaviour is unsigned.
- SEQ_MUL_SIGNED_EN undefined:
  - No is_signed port.
  - Unsigned only.
  - No negation logic.

## Structure
- Package seq_mul_pkg holds:
  - the state enum (IDLE, RUN, DONE)
  - default WIDTH
  - counter width CNT_W = $clog2(WIDTH)+1
- One sub-module, seq_mul_step: combinational conditional-add-and-shift of the accumulator, parameterised by WIDTH.
- FSM, counter, operand/sign registers and the output register live in seq_multiplier.

## Test plan
- Reset, then 3 × 5 → finish rises exactly 33 edges after the start edge; product=0x0000_0000_0000_000F; busy is low thereafter.
- 0xFFFF_FFFF × 0xFFFF_FFFF unsigned → product=0xFFFF_FFFE_0000_0001. A second start in the DONE cycle drops finish the next cycle.
- start pulsed and operands changed at iteration 10 of 0x1234 × 0x10 → ignored; product=0x12340.
- rst pulsed at iteration 16 of 7 × 9 → outputs return to 0 immediately; no finish. A new 7 × 9 start gives 63.
- With SEQ_MUL_SIGNED_EN and is_signed=1:
  - −3 × 7 → 0xFFFF_FFFF_FFFF_FFEB
  - 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000
  - Latency remains 33 edges.
- 0 × 0xDEAD_BEEF → product=0 after the full 33 edges (no early finish).
